// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ sources.
// Handles completion, stop-bit guard time and timeout recovery.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GUARD_CYCLES   = 5208,
  parameter int TIMEOUT_CYCLES = 60000,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GUARD
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [19:0]     cnt;
  logic            done_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic            hit;
  logic            done_rise;
  logic            to_hit;
  logic            guard_hit;
  int              idx;

  assign done_rise = tx_done & ~done_d;
  assign to_hit    = (cnt == 20'(TIMEOUT_CYCLES - 1));
  assign guard_hit = (cnt == 20'(GUARD_CYCLES - 1));
  assign busy      = (state != IDLE);

  // First valid source strictly after the last winner, wrapping.
  always_comb begin
    win = rr_ptr;
    hit = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        win = ID_W'(idx);
      end
    end
  end

  assign req_ready = (state == IDLE && hit) ?
                     (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (hit) state_n = BUSY;
      BUSY:    if (done_rise || to_hit) state_n = GUARD;
      GUARD:   if (guard_hit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      done_d      <= 1'b0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
    end else begin
      done_d      <= tx_done;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            tx_data  <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            grant_id <= win;
            rr_ptr   <= win;
            tx_valid <= 1'b1;
            cnt      <= '0;
          end
        end
        BUSY: begin
          // A coincident done takes priority, so no error is flagged.
          if (done_rise) begin
            tx_valid <= 1'b0;
            cnt      <= '0;
          end else if (to_hit) begin
            tx_valid    <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        GUARD: begin
          if (guard_hit) cnt <= '0;
          else           cnt <= cnt + 20'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// NUM_REQ=4, GUARD_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_uart_tx_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .GUARD_CYCLES(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic serve(input int id, input logic [7:0] d, input int dly);
    int n;
    n = 0;
    while (!tx_valid && n < 60) begin
      step();
      n++;
    end
    chk($sformatf("grant%0d_valid", id), 32'(tx_valid), 1);
    chk($sformatf("grant%0d_id", id), 32'(grant_id), id);
    chk($sformatf("grant%0d_data", id), 32'(tx_data), 32'(d));
    repeat (dly - 1) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk($sformatf("grant%0d_drop", id), 32'(tx_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    tx_done   = 1'b0;
    #2;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0;

    // single word
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    chk("t1_valid", 32'(tx_valid), 1);
    chk("t1_data", 32'(tx_data), 32'h55);
    chk("t1_id", 32'(grant_id), 0);
    chk("t1_ready_off", 32'(req_ready), 0);
    repeat (5) step();
    chk("t1_hold", 32'(tx_valid), 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t1_drop", 32'(tx_valid), 0);
    chk("t1_guard0", 32'(busy), 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("t1_guard%0d", i), 32'(busy), 1);
    end
    step();
    chk("t1_idle", 32'(busy), 0);
    chk("t1_keep_data", 32'(tx_data), 32'h55);
    req_data[7:0] = 8'h10;

    // round-robin
    do_reset();
    req_valid = 4'b1111;
    serve(0, 8'h10, 3);
    serve(1, 8'h11, 3);
    serve(2, 8'h12, 3);
    serve(3, 8'h13, 3);
    serve(0, 8'h10, 3);
    req_valid = 4'b0000;

    // pointer wrap
    do_reset();
    req_valid = 4'b0100;
    serve(2, 8'h12, 2);
    req_valid = 4'b1010;
    serve(3, 8'h13, 2);
    serve(1, 8'h11, 2);
    req_valid = 4'b0000;

    // timeout
    do_reset();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    n = 0;
    while (tx_valid && n < 40) begin
      chk("t4_no_err", 32'(timeout_err), 0);
      step();
      n++;
    end
    chk("t4_high_len", 32'(n), 20);
    chk("t4_err", 32'(timeout_err), 1);
    req_valid = 4'b0010;
    step();
    chk("t4_err_pulse", 32'(timeout_err), 0);
    n = 0;
    while (!tx_valid && n < 40) begin
      step();
      n++;
    end
    chk("t4_guard_gap", 32'(n), 4);
    chk("t4_next_id", 32'(grant_id), 1);
    req_valid = 4'b0000;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t4_next_drop", 32'(tx_valid), 0);
    chk("t4_next_noerr", 32'(timeout_err), 0);

    // stale done
    do_reset();
    tx_done   = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    chk("t5_valid", 32'(tx_valid), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_stale%0d", i), 32'(tx_valid), 1);
    end
    tx_done = 1'b0;
    step();
    chk("t5_low", 32'(tx_valid), 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("t5_drop", 32'(tx_valid), 0);
    chk("t5_noerr", 32'(timeout_err), 0);

    // reset mid-BUSY
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    step();
    chk("t6_pre", 32'(tx_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    req_valid = 4'b1111;
    step();
    rst = 1'b0;
    step();
    chk("t6_valid", 32'(tx_valid), 1);
    chk("t6_id", 32'(grant_id), 0);
    chk("t6_data", 32'(tx_data), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
